// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared definitions for the common-bus arbiter: FSM state encoding,
//   source count, index width and a one-hot helper.
package bus_arbiter_pkg;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  function automatic logic [NUM_SRC-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker
//   Combinational rotating-priority picker. Scans req upward starting at
//   (last+1) mod NUM_SRC, wrapping, and returns the first set bit.
//   Ports:
//     req   - per-source request vector
//     last  - index of the previous owner
//     found - high when any request bit is set
//     idx   - index of the selected source (0 when found is low)
module rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      // 3-bit addition wraps naturally over the 8 sources
      w_cand = last + IDX_W'(k + 1);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter for an 8-source common bus. An owner keeps the bus
//   while it requests, up to MAX_HOLD cycles (0 = unlimited); each tenure
//   ends with one turnaround cycle with no grant before the next decision.
//   Parameters:
//     MAX_HOLD - maximum cycles per tenure, 0 disables the limit
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - synchronous active-low reset
//     enable - allows new grants to be issued from IDLE
//     req    - per-source request vector
//     grant  - one-hot current owner, or zero
//     sel    - binary index of the owner, 0 when no grant
//     busy   - high whenever grant is non-zero
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   sel,
  output logic               busy
);

  state_t             r_state;
  logic [NUM_SRC-1:0] r_grant;
  logic [IDX_W-1:0]   r_sel;
  logic               r_busy;
  logic [3:0]         r_hold;
  logic [IDX_W-1:0]   r_last;

  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hold_done;
  logic               w_owner_req;

  rr_picker u_picker (
    .req   (req),
    .last  (r_last),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_hold_done = (MAX_HOLD != 0) && ({28'd0, r_hold} == MAX_HOLD);
  // r_last always holds the current owner's index while in OWN
  assign w_owner_req = req[r_last];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_hold  <= '0;
      r_last  <= IDX_W'(NUM_SRC - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && w_found) begin
            r_state <= OWN;
            r_grant <= idx_to_onehot(w_idx);
            r_sel   <= w_idx;
            r_busy  <= 1'b1;
            r_hold  <= 4'd1;
            r_last  <= w_idx;
          end
        end
        OWN: begin
          if (!w_owner_req || w_hold_done) begin
            r_state <= TURN;
            r_grant <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
          end else if (r_hold != 4'hF) begin
            r_hold <= r_hold + 4'd1;
          end
        end
        TURN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_sel   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed scoreboard bench for bus_arbiter. Two instances: one with
//   MAX_HOLD=15, one with MAX_HOLD=0 (unlimited hold).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst0_n, en0, rst1_n, en1;
  logic [7:0] req0, req1;
  logic [7:0] grant0, grant1;
  logic [2:0] sel0, sel1;
  logic       busy0, busy1;

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    int unsigned tag;
    bit          which;
    logic [7:0]  g;
    logic [2:0]  s;
    logic        b;
    int unsigned sid;
  } exp_t;

  exp_t  q[$];
  string names[7] = '{"reset", "hold15", "rotate", "owner3", "enable", "midreset", "nohold"};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bus_arbiter #(.MAX_HOLD(15)) dut0 (
    .clk(clk), .rst_n(rst0_n), .enable(en0), .req(req0),
    .grant(grant0), .sel(sel0), .busy(busy0)
  );

  bus_arbiter #(.MAX_HOLD(0)) dut1 (
    .clk(clk), .rst_n(rst1_n), .enable(en1), .req(req1),
    .grant(grant1), .sel(sel1), .busy(busy1)
  );

  function automatic logic [2:0] enc(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Monitor: pops every expectation due this cycle and compares
  always @(negedge clk) begin
    logic [7:0] ag;
    logic [2:0] as;
    logic       ab;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      ag = e.which ? grant1 : grant0;
      as = e.which ? sel1   : sel0;
      ab = e.which ? busy1  : busy0;
      checks++;
      if (e.tag != cyc) begin
        errors++;
        $display("FAIL %s_late cyc=%0d got tag=%0d required tag=%0d", names[e.sid], cyc, e.tag, cyc);
      end
      checks++;
      if (ag !== e.g) begin
        errors++;
        $display("FAIL %s_grant dut%0d cyc=%0d got %h required %h", names[e.sid], e.which, cyc, ag, e.g);
      end
      checks++;
      if (as !== e.s) begin
        errors++;
        $display("FAIL %s_sel dut%0d cyc=%0d got %0d required %0d", names[e.sid], e.which, cyc, as, e.s);
      end
      checks++;
      if (ab !== e.b) begin
        errors++;
        $display("FAIL %s_busy dut%0d cyc=%0d got %b required %b", names[e.sid], e.which, cyc, ab, e.b);
      end
    end
    // Structural invariants on the free-running instance
    checks++;
    if ($countones(grant0) > 1 || sel0 !== enc(grant0) || busy0 !== (grant0 != 8'h00)) begin
      errors++;
      $display("FAIL invariant cyc=%0d got grant=%h sel=%0d busy=%b required onehot/encoded", cyc, grant0, sel0, busy0);
    end
  end

  task automatic step(input bit which, input logic rst, input logic e, input logic [7:0] r,
                      input logic [7:0] eg, input logic [2:0] es, input int unsigned sid);
    exp_t x;
    if (which) begin rst1_n = rst; en1 = e; req1 = r; end
    else       begin rst0_n = rst; en0 = e; req0 = r; end
    x.tag = cyc + 1; x.which = which; x.g = eg; x.s = es; x.b = (eg != 8'h00); x.sid = sid;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0_n = 1'b0; en0 = 1'b0; req0 = '0;
    rst1_n = 1'b0; en1 = 1'b0; req1 = '0;
    @(posedge clk);
    #1;

    // Reset state, then single requester held for a full MAX_HOLD tenure
    step(0, 0, 1, 8'h01, 8'h00, 0, 0);
    step(0, 0, 1, 8'h01, 8'h00, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 1, 8'h01, 8'h01, 0, 1);
    step(0, 1, 1, 8'h01, 8'h00, 0, 1);   // TURN
    step(0, 1, 1, 8'h01, 8'h00, 0, 1);   // IDLE
    step(0, 1, 1, 8'h01, 8'h01, 0, 1);   // regranted
    step(0, 1, 1, 8'h00, 8'h00, 0, 1);
    step(0, 1, 1, 8'h00, 8'h00, 0, 1);

    // All requests high: rotation 0..7,0 with 15-cycle tenures
    step(0, 0, 1, 8'hFF, 8'h00, 0, 2);
    for (int o = 0; o < 9; o++) begin
      for (int i = 0; i < 15; i++) step(0, 1, 1, 8'hFF, 8'h01 << (o % 8), 3'(o % 8), 2);
      if (o < 8) begin
        step(0, 1, 1, 8'hFF, 8'h00, 0, 2);
        step(0, 1, 1, 8'hFF, 8'h00, 0, 2);
      end
    end
    step(0, 1, 1, 8'h00, 8'h00, 0, 2);
    step(0, 1, 1, 8'h00, 8'h00, 0, 2);

    // Owner 3 with req[7] also pending; owner drops after 4 cycles
    step(0, 1, 1, 8'h08, 8'h08, 3, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h88, 8'h08, 3, 3);
    step(0, 1, 1, 8'h80, 8'h00, 0, 3);   // TURN
    step(0, 1, 1, 8'h80, 8'h00, 0, 3);   // IDLE
    step(0, 1, 1, 8'h80, 8'h80, 7, 3);
    step(0, 1, 1, 8'h00, 8'h00, 0, 3);
    step(0, 1, 1, 8'h00, 8'h00, 0, 3);

    // Enable gating and grant retention while enable drops
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h10, 8'h00, 0, 4);
    step(0, 1, 1, 8'h10, 8'h10, 4, 4);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h10, 8'h10, 4, 4);
    step(0, 1, 0, 8'h00, 8'h00, 0, 4);
    step(0, 1, 0, 8'h00, 8'h00, 0, 4);
    step(0, 1, 0, 8'h10, 8'h00, 0, 4);

    // Reset while owning; last returns to 7 so source 1 wins 8'h06
    step(0, 1, 1, 8'h10, 8'h10, 4, 5);
    step(0, 1, 1, 8'h10, 8'h10, 4, 5);
    step(0, 0, 1, 8'h10, 8'h00, 0, 5);
    step(0, 1, 1, 8'h06, 8'h02, 1, 5);
    step(0, 1, 1, 8'h00, 8'h00, 0, 5);
    step(0, 1, 1, 8'h00, 8'h00, 0, 5);

    // Unlimited hold instance
    step(1, 0, 1, 8'h04, 8'h00, 0, 6);
    for (int i = 0; i < 40; i++) step(1, 1, 1, 8'h04, 8'h04, 2, 6);
    step(1, 1, 1, 8'h00, 8'h00, 0, 6);
    step(1, 1, 1, 8'h00, 8'h00, 0, 6);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
